// File: rtl/jump_target_encoder.sv
// jump_target_encoder
//
// Builds a J-type jump word (J / JAL) from an absolute target address so the
// core's {4'b0000, field, 2'b00} expansion reproduces that target. Results go
// through a two-entry in-order buffer with valid/ready handshakes on both sides.
// Targets the expansion cannot reproduce are still encoded, but are flagged.
//
// Optional feature macro: JUMP_REGION_CHECK_EN
//   defined   : region error when target[31:28] differs from (pc + 4)[31:28]
//   undefined : region error when target[31:28] is non-zero (in_pc unused)
//
// Parameters
//   CNT_WIDTH       width of the saturating error counter
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   in_valid        request present
//   in_ready        buffer can accept (registered state only)
//   in_link         1 = JAL (opcode 6'h03), 0 = J (opcode 6'h02)
//   in_pc           address of the jump instruction
//   in_target       absolute jump target
//   out_valid       head entry valid
//   out_ready       consumer accepts the head entry
//   out_instr       encoded instruction word of the head entry
//   out_err_align   head entry target not word-aligned
//   out_err_region  head entry target outside the reachable region
//   err_count       accepted entries with any error, saturating

module jump_target_encoder #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_link,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err_align,
    output logic                 out_err_region,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [5:0] OpJ   = 6'h02;
    localparam logic [5:0] OpJal = 6'h03;

    typedef struct packed {
        logic [31:0] instr;
        logic        err_align;
        logic        err_region;
    } entry_t;

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    entry_t new_entry;
    logic   push;
    logic   pop;

    // ------------------------------------------------------------------
    // Encoding of the incoming request
    // ------------------------------------------------------------------
`ifdef JUMP_REGION_CHECK_EN
    logic [31:0] pc4;
    assign pc4 = in_pc + 32'd4;  // wraps to 0 from 0xFFFF_FFFC

    always_comb begin
        new_entry            = '0;
        new_entry.instr      = {(in_link ? OpJal : OpJ), in_target[27:2]};
        new_entry.err_align  = (in_target[1:0] != 2'b00);
        new_entry.err_region = (in_target[31:28] != pc4[31:28]);
    end
`else
    // The core zero-fills the upper nibble, so the jump PC is irrelevant here.
    logic unused_pc;
    assign unused_pc = ^in_pc;

    always_comb begin
        new_entry            = '0;
        new_entry.instr      = {(in_link ? OpJal : OpJ), in_target[27:2]};
        new_entry.err_align  = (in_target[1:0] != 2'b00);
        new_entry.err_region = (in_target[31:28] != 4'b0000);
    end
`endif

    // ------------------------------------------------------------------
    // Handshakes: in_ready depends only on registered occupancy
    // ------------------------------------------------------------------
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next-state: occupancy and buffer contents
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = new_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    // Head leaves and the new entry takes its place.
                    head_d = new_entry;
                end else if (push) begin
                    tail_d  = new_entry;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating error counter
    // ------------------------------------------------------------------
    always_comb begin
        err_count_d = err_count_q;
        if (push && (new_entry.err_align || new_entry.err_region) &&
            (err_count_q != {CNT_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            head_q      <= '0;
            tail_q      <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            err_count_q <= err_count_d;
        end
    end

    // Outputs come straight from the head register.
    assign out_instr      = head_q.instr;
    assign out_err_align  = head_q.err_align;
    assign out_err_region = head_q.err_region;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_jump_target_encoder.sv
// Directed bench for jump_target_encoder. A second instance with CNT_WIDTH=2
// shares all inputs and is used for the counter saturation check.
// Inputs change and outputs are sampled on the falling edge.

module tb_jump_target_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_link;
    logic [31:0] in_pc;
    logic [31:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err_align;
    logic        out_err_region;
    logic [7:0]  err_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic        out_err_align2;
    logic        out_err_region2;
    logic [1:0]  err_count2;

    int nvec;
    int nmis;
    int exp_cnt;

    jump_target_encoder #(.CNT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_link        (in_link),
        .in_pc          (in_pc),
        .in_target      (in_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_err_align  (out_err_align),
        .out_err_region (out_err_region),
        .err_count      (err_count)
    );

    jump_target_encoder #(.CNT_WIDTH(2)) dut_sat (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready2),
        .in_link        (in_link),
        .in_pc          (in_pc),
        .in_target      (in_target),
        .out_valid      (out_valid2),
        .out_ready      (out_ready),
        .out_instr      (out_instr2),
        .out_err_align  (out_err_align2),
        .out_err_region (out_err_region2),
        .err_count      (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; presents one request for a single rising edge.
    task automatic send(input logic link, input logic [31:0] pc, input logic [31:0] tgt);
        in_valid  = 1'b1;
        in_link   = link;
        in_pc     = pc;
        in_target = tgt;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    initial begin
        nvec      = 0;
        nmis      = 0;
        exp_cnt   = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_link   = 1'b0;
        in_pc     = '0;
        in_target = '0;
        out_ready = 1'b1;

        // Reset values
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_flags", {30'd0, out_err_align, out_err_region}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic J
        send(1'b0, 32'h0040_0000, 32'h0040_0020);
        check("j_valid", {31'd0, out_valid}, 32'd1);
        check("j_instr", out_instr, 32'h0810_0008);
        check("j_flags", {30'd0, out_err_align, out_err_region}, 32'd0);
        check("j_err_count", {24'd0, err_count}, 32'd0);

        // JAL
        send(1'b1, 32'h0040_0000, 32'h0040_0020);
        check("jal_instr", out_instr, 32'h0C10_0008);
        check("jal_valid", {31'd0, out_valid}, 32'd1);

        // Misaligned
        send(1'b0, 32'h0040_0000, 32'h0040_0022);
        exp_cnt = 1;
        check("mis_instr", out_instr, 32'h0810_0008);
        check("mis_align", {31'd0, out_err_align}, 32'd1);
        check("mis_region", {31'd0, out_err_region}, 32'd0);
        check("mis_err_count", {24'd0, err_count}, exp_cnt);

        // Region: pc4 crosses into region 1, target in region 0
        send(1'b0, 32'h0FFF_FFFC, 32'h0000_0100);
        check("reg_instr", out_instr, 32'h0800_0040);
        check("reg_align", {31'd0, out_err_align}, 32'd0);
`ifdef JUMP_REGION_CHECK_EN
        exp_cnt = exp_cnt + 1;
        check("reg_region", {31'd0, out_err_region}, 32'd1);
`else
        check("reg_region", {31'd0, out_err_region}, 32'd0);
`endif
        check("reg_err_count", {24'd0, err_count}, exp_cnt);

        // PC wrap: pc4 = 0, same region as target
        send(1'b0, 32'hFFFF_FFFC, 32'h0000_0100);
        check("wrap_instr", out_instr, 32'h0800_0040);
        check("wrap_region", {31'd0, out_err_region}, 32'd0);
        check("wrap_err_count", {24'd0, err_count}, exp_cnt);

        // Target in region 1: only the zero-nibble rule objects
        send(1'b0, 32'h0FFF_FFFC, 32'h1000_0000);
        check("hi_instr", out_instr, 32'h0800_0000);
`ifdef JUMP_REGION_CHECK_EN
        check("hi_region", {31'd0, out_err_region}, 32'd0);
`else
        exp_cnt = exp_cnt + 1;
        check("hi_region", {31'd0, out_err_region}, 32'd1);
`endif
        check("hi_err_count", {24'd0, err_count}, exp_cnt);

        // Drain
        @(negedge clk);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure: A, B accepted, C held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_link   = 1'b0;
        in_pc     = 32'h0;
        in_target = 32'h0000_0010;
        @(negedge clk);
        check("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_a_instr", out_instr, 32'h0800_0004);
        in_target = 32'h0000_0020;
        @(negedge clk);
        check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_full_valid", {31'd0, out_valid}, 32'd1);
        check("bp_full_instr", out_instr, 32'h0800_0004);
        in_target = 32'h0000_0030;
        @(negedge clk);
        check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_instr", out_instr, 32'h0800_0004);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b_instr", out_instr, 32'h0800_0008);
        check("bp_b_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_c_instr", out_instr, 32'h0800_000C);
        check("bp_c_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        check("bp_err_count", {24'd0, err_count}, exp_cnt);

        // Saturation: clear, then five misaligned back-to-back
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("sat_start", {30'd0, err_count2}, 32'd0);
        in_valid  = 1'b1;
        in_link   = 1'b0;
        in_pc     = 32'h0;
        in_target = 32'h0000_0001;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("sat_w2", {30'd0, err_count2}, 32'd3);
        check("sat_w8", {24'd0, err_count}, 32'd5);
        check("sat_align", {31'd0, out_err_align}, 32'd1);

        // Asynchronous reset with the buffer full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_target = 32'h0000_0040;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_err_count", {24'd0, err_count}, 32'd0);
        check("arst_instr", out_instr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("post_rst_valid2", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
